// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: direction encoding, default sizing and
// helpers used to size and check counter ranges at elaboration time.
package counter_pkg;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } count_dir_e;

  // Modulus of a counter that uses every code of a given width.
  function automatic longint unsigned full_modulus(input int unsigned width);
    return 64'd1 << width;
  endfunction

  // Number of bits needed to hold the largest count value, MODULUS-1.
  function automatic int unsigned value_width(input longint unsigned modulus);
    longint unsigned max_val;
    int unsigned     w;
    max_val = modulus - 64'd1;
    w       = 1;
    for (int b = 1; b < 64; b++) begin
      if ((max_val >> b) != 64'd0) begin
        w = b + 1;
      end
    end
    return w;
  endfunction

  localparam int unsigned     DEFAULT_WIDTH   = 4;
  localparam longint unsigned DEFAULT_MODULUS = full_modulus(DEFAULT_WIDTH);

endpackage

// File: rtl/counter_next_value.sv
// Combinational next-count logic: computes the stepped value, range-end detection and
// the cascade terminal-count strobe for an up/down counter of arbitrary modulus.
module counter_next_value
  import counter_pkg::*;
#(
  parameter int              WIDTH   = DEFAULT_WIDTH,
  parameter longint unsigned MODULUS = full_modulus(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic             down,
  input  logic             saturate,
  input  logic             enable,
  input  logic             step,
  output logic [WIDTH-1:0] next_a,
  output logic             range_end_hit,
  output logic             output_carry
);

  localparam longint unsigned MAX_VAL = MODULUS - 64'd1;
  localparam logic [WIDTH:0]  MOD_EXT = MODULUS[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_A  = MAX_VAL[WIDTH-1:0];

  count_dir_e     dir;
  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;
  logic           at_end;

  assign dir      = down ? DOWN : UP;
  assign a_ext    = {1'b0, a};
  assign sum_ext  = a_ext + {{WIDTH{1'b0}}, 1'b1};
  assign diff_ext = a_ext - {{WIDTH{1'b0}}, 1'b1};

  // One extra bit keeps the top-end compare exact even when MODULUS == 2**WIDTH,
  // and the borrow out of the subtraction marks the bottom end.
  always_comb begin
    at_end = 1'b0;
    next_a = a;
    if (dir == UP) begin
      at_end = (sum_ext == MOD_EXT);
      if (!at_end) begin
        next_a = sum_ext[WIDTH-1:0];
      end else if (!saturate) begin
        next_a = '0;
      end
    end else begin
      at_end = diff_ext[WIDTH];
      if (!at_end) begin
        next_a = diff_ext[WIDTH-1:0];
      end else if (!saturate) begin
        next_a = MAX_A;
      end
    end
  end

  assign output_carry  = enable & at_end;
  assign range_end_hit = step & at_end;

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down modulo counter with parallel load clamp, wrap/saturate modes,
// cascade carry and a sticky overflow flag.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int              WIDTH   = DEFAULT_WIDTH,
  parameter longint unsigned MODULUS = full_modulus(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             sync_clear,
  input  logic             load,
  input  logic             increment,
  input  logic             carry_in,
  input  logic             down,
  input  logic             saturate,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] A,
  output logic             output_carry,
  output logic             overflow,
  output logic             load_err
);

  localparam longint unsigned MAX_VAL = MODULUS - 64'd1;
  localparam logic [WIDTH:0]  MOD_EXT = MODULUS[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_A  = MAX_VAL[WIDTH-1:0];
  localparam int unsigned     VALUE_W = value_width(MODULUS);

  // Refuse to elaborate an impossible configuration rather than build a broken counter.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be in 2..32");
  end
  if (MODULUS < 64'd2 || MODULUS > full_modulus(WIDTH) || VALUE_W > WIDTH) begin : g_bad_modulus
    $error("updown_counter_param: MODULUS must be in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] a_next;
  logic             overflow_reg;
  logic             overflow_next;
  logic             load_err_reg;
  logic             load_err_next;

  logic             count_enable;
  logic             step;
  logic             load_clamp;
  logic [WIDTH-1:0] counted_a;
  logic             range_end_hit;

  assign count_enable = increment & carry_in;
  assign step         = count_enable & ~load & ~sync_clear;
  assign load_clamp   = ({1'b0, I} >= MOD_EXT);

  counter_next_value #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next_value (
    .a             (a_reg),
    .down          (down),
    .saturate      (saturate),
    .enable        (count_enable),
    .step          (step),
    .next_a        (counted_a),
    .range_end_hit (range_end_hit),
    .output_carry  (output_carry)
  );

  // Edge priority: sync_clear, then load, then a count step, otherwise hold.
  always_comb begin
    a_next        = a_reg;
    overflow_next = overflow_reg;
    load_err_next = 1'b0;
    if (sync_clear) begin
      a_next        = '0;
      overflow_next = 1'b0;
    end else if (load) begin
      if (load_clamp) begin
        a_next        = MAX_A;
        load_err_next = 1'b1;
      end else begin
        a_next = I;
      end
    end else if (step) begin
      a_next = counted_a;
      if (range_end_hit) begin
        overflow_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      a_reg        <= '0;
      overflow_reg <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      a_reg        <= a_next;
      overflow_reg <= overflow_next;
      load_err_reg <= load_err_next;
    end
  end

  assign A        = a_reg;
  assign overflow = overflow_reg;
  assign load_err = load_err_reg;

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench: a modulo-10 counter, a full-range modulo-16 counter and a two-digit
// modulo-10 cascade, all driven together and checked against an arithmetic model.
module tb_updown_counter_param;

  typedef struct {
    bit sclr;
    bit ld;
    bit inc;
    bit cin;
    bit dn;
    bit sat;
    int i;
  } stim_t;

  typedef struct {
    bit kind;  // 1: check state immediately (async clear), 0: check after the next edge
    int a0; bit ovf0; bit lerr0; bit car0;
    int a1; bit ovf1; bit lerr1; bit car1;
    int lo; int hi; bit lo_car; bit hi_car; bit lo_ovf; bit hi_ovf;
  } exp_t;

  logic       clk;
  logic       clr;
  logic       sclr   [2];
  logic       ld     [2];
  logic       inc    [2];
  logic       cin    [2];
  logic       dn     [2];
  logic       sat    [2];
  logic [3:0] ld_val [2];
  logic [3:0] a_out  [2];
  logic       car    [2];
  logic       ovf    [2];
  logic       lerr   [2];

  logic       c_inc;
  logic       c_sclr;
  logic [3:0] lo_a, hi_a;
  logic       lo_car, hi_car, lo_ovf, hi_ovf, lo_lerr, hi_lerr;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  bit   drv_done = 0;

  int   m_a   [2];
  bit   m_ovf [2];
  bit   m_lerr[2];
  int   mods  [2] = '{10, 16};
  int   cas_n;
  bit   cas_lo_ovf, cas_hi_ovf;

  updown_counter_param #(.WIDTH(4), .MODULUS(10)) dut_mod10 (
    .clock(clk), .clear(clr), .sync_clear(sclr[0]), .load(ld[0]), .increment(inc[0]),
    .carry_in(cin[0]), .down(dn[0]), .saturate(sat[0]), .I(ld_val[0]), .A(a_out[0]),
    .output_carry(car[0]), .overflow(ovf[0]), .load_err(lerr[0])
  );

  updown_counter_param #(.WIDTH(4), .MODULUS(16)) dut_mod16 (
    .clock(clk), .clear(clr), .sync_clear(sclr[1]), .load(ld[1]), .increment(inc[1]),
    .carry_in(cin[1]), .down(dn[1]), .saturate(sat[1]), .I(ld_val[1]), .A(a_out[1]),
    .output_carry(car[1]), .overflow(ovf[1]), .load_err(lerr[1])
  );

  updown_counter_param #(.WIDTH(4), .MODULUS(10)) dut_lo (
    .clock(clk), .clear(clr), .sync_clear(c_sclr), .load(1'b0), .increment(c_inc),
    .carry_in(1'b1), .down(1'b0), .saturate(1'b0), .I(4'd0), .A(lo_a),
    .output_carry(lo_car), .overflow(lo_ovf), .load_err(lo_lerr)
  );

  updown_counter_param #(.WIDTH(4), .MODULUS(10)) dut_hi (
    .clock(clk), .clear(clr), .sync_clear(c_sclr), .load(1'b0), .increment(c_inc),
    .carry_in(lo_car), .down(1'b0), .saturate(1'b0), .I(4'd0), .A(hi_a),
    .output_carry(hi_car), .overflow(hi_ovf), .load_err(hi_lerr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t mk(bit s, bit l, bit n, bit c, bit d, bit t, int i);
    stim_t r;
    r.sclr = s; r.ld = l; r.inc = n; r.cin = c; r.dn = d; r.sat = t; r.i = i;
    return r;
  endfunction

  function automatic stim_t rnd_stim();
    return mk(($urandom_range(19) == 0), ($urandom_range(5) == 0), ($urandom_range(3) != 0),
              ($urandom_range(3) != 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
              int'($urandom_range(15)));
  endfunction

  function automatic bit exp_carry(int d, stim_t s);
    return s.inc && s.cin && (s.dn ? (m_a[d] == 0) : (m_a[d] == mods[d] - 1));
  endfunction

  // Reference behaviour of one edge, written straight from the counting rules.
  task automatic model_edge(int d, stim_t s);
    int m;
    m         = mods[d];
    m_lerr[d] = 0;
    if (s.sclr) begin
      m_a[d] = 0; m_ovf[d] = 0;
    end else if (s.ld) begin
      if (s.i < m) m_a[d] = s.i;
      else begin m_a[d] = m - 1; m_lerr[d] = 1; end
    end else if (s.inc && s.cin) begin
      if (!s.dn) begin
        if (m_a[d] == m - 1) begin m_ovf[d] = 1; if (!s.sat) m_a[d] = 0; end
        else m_a[d] = m_a[d] + 1;
      end else begin
        if (m_a[d] == 0) begin m_ovf[d] = 1; if (!s.sat) m_a[d] = m - 1; end
        else m_a[d] = m_a[d] - 1;
      end
    end
  endtask

  task automatic drive(stim_t s0, stim_t s1, bit ci, bit cs);
    clr = 1'b0;
    sclr[0] = s0.sclr; ld[0] = s0.ld; inc[0] = s0.inc; cin[0] = s0.cin;
    dn[0] = s0.dn; sat[0] = s0.sat; ld_val[0] = 4'(s0.i);
    sclr[1] = s1.sclr; ld[1] = s1.ld; inc[1] = s1.inc; cin[1] = s1.cin;
    dn[1] = s1.dn; sat[1] = s1.sat; ld_val[1] = 4'(s1.i);
    c_inc = ci; c_sclr = cs;
  endtask

  function automatic exp_t snapshot(bit kind);
    exp_t e;
    e.kind = kind;
    e.a0 = m_a[0]; e.ovf0 = m_ovf[0]; e.lerr0 = m_lerr[0]; e.car0 = 0;
    e.a1 = m_a[1]; e.ovf1 = m_ovf[1]; e.lerr1 = m_lerr[1]; e.car1 = 0;
    e.lo = cas_n % 10; e.hi = cas_n / 10; e.lo_car = 0; e.hi_car = 0;
    e.lo_ovf = cas_lo_ovf; e.hi_ovf = cas_hi_ovf;
    return e;
  endfunction

  task automatic cycle(stim_t s0, stim_t s1, bit ci, bit cs);
    exp_t e;
    bit c0, c1, lc, hc;
    drive(s0, s1, ci, cs);
    c0 = exp_carry(0, s0);
    c1 = exp_carry(1, s1);
    lc = ci && (cas_n % 10 == 9);
    hc = ci && lc && (cas_n / 10 == 9);
    model_edge(0, s0);
    model_edge(1, s1);
    if (cs) begin
      cas_n = 0; cas_lo_ovf = 0; cas_hi_ovf = 0;
    end else if (ci) begin
      if (cas_n % 10 == 9) cas_lo_ovf = 1;
      if (cas_n == 99) cas_hi_ovf = 1;
      cas_n = (cas_n + 1) % 100;
    end
    e = snapshot(1'b0);
    e.car0 = c0; e.car1 = c1; e.lo_car = lc; e.hi_car = hc;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic async_clear();
    stim_t idle;
    idle = mk(0, 0, 0, 1, 0, 0, 0);
    drive(idle, idle, 1'b0, 1'b0);
    clr = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_a[d] = 0; m_ovf[d] = 0; m_lerr[d] = 0;
    end
    cas_n = 0; cas_lo_ovf = 0; cas_hi_ovf = 0;
    sb_q.push_back(snapshot(1'b1));
    @(negedge clk);
  endtask

  // Stimulus
  initial begin
    stim_t idle;
    idle = mk(0, 0, 0, 1, 0, 0, 0);
    drive(idle, idle, 1'b0, 1'b0);
    clr = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_a[d] = 0; m_ovf[d] = 0; m_lerr[d] = 0;
    end
    cas_n = 0; cas_lo_ovf = 0; cas_hi_ovf = 0;
    @(negedge clk);
    async_clear();
    // Mid-count async clear, then load 7 with increment also high.
    cycle(mk(0, 1, 0, 1, 0, 0, 5), mk(0, 1, 0, 1, 0, 0, 15), 1'b0, 1'b1);
    cycle(mk(0, 0, 1, 1, 0, 0, 0), mk(0, 0, 1, 1, 0, 0, 0), 1'b0, 1'b0);
    cycle(mk(0, 0, 1, 1, 0, 0, 0), mk(0, 0, 1, 1, 1, 0, 0), 1'b0, 1'b0);
    async_clear();
    cycle(mk(0, 1, 1, 1, 0, 0, 7), mk(1, 1, 0, 1, 0, 0, 15), 1'b0, 1'b1);
    // Wrap up 7 -> 8,9,0,1; modulo-16 counts down from 0 to 15 on the first edge.
    cycle(mk(0, 0, 1, 1, 0, 0, 0), mk(0, 0, 1, 1, 1, 0, 0), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(mk(0, 0, 1, 1, 0, 0, 0), idle, 1'b0, 1'b0);
    // Saturating down from 1, then clamp and a plain load.
    cycle(mk(0, 1, 0, 1, 0, 0, 1), mk(0, 1, 0, 1, 0, 0, 15), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      cycle(mk(0, 0, 1, 1, 1, 1, 0), mk(0, 0, 1, 1, 0, 1, 0), 1'b0, 1'b0);
    cycle(mk(0, 1, 0, 1, 0, 0, 13), mk(0, 0, 1, 1, 0, 0, 0), 1'b0, 1'b0);
    cycle(mk(0, 1, 0, 1, 0, 0, 4), idle, 1'b0, 1'b0);
    // Load at the top end with an up count requested: load wins, carry still reflects A=9.
    cycle(mk(0, 1, 0, 1, 0, 0, 9), idle, 1'b0, 1'b0);
    cycle(mk(0, 1, 1, 1, 0, 0, 3), mk(1, 1, 1, 1, 0, 0, 9), 1'b0, 1'b0);
    // Cascade: 25 steps from 00.
    for (int k = 0; k < 25; k++) cycle(rnd_stim(), rnd_stim(), 1'b1, 1'b0);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(49) == 0) async_clear();
      else cycle(rnd_stim(), rnd_stim(), 1'($urandom_range(3) != 0), ($urandom_range(39) == 0));
    end
    drv_done = 1;
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(exp_t e);
    chk("mod10_A", int'(a_out[0]), e.a0);
    chk("mod10_overflow", int'(ovf[0]), int'(e.ovf0));
    chk("mod10_load_err", int'(lerr[0]), int'(e.lerr0));
    chk("mod16_A", int'(a_out[1]), e.a1);
    chk("mod16_overflow", int'(ovf[1]), int'(e.ovf1));
    chk("mod16_load_err", int'(lerr[1]), int'(e.lerr1));
    chk("cascade_low_A", int'(lo_a), e.lo);
    chk("cascade_high_A", int'(hi_a), e.hi);
    chk("cascade_low_overflow", int'(lo_ovf), int'(e.lo_ovf));
    chk("cascade_high_overflow", int'(hi_ovf), int'(e.hi_ovf));
    chk("cascade_low_load_err", int'(lo_lerr), 0);
    chk("cascade_high_load_err", int'(hi_lerr), 0);
  endtask

  // Monitor: pops one expectation per presented cycle
  initial begin
    exp_t e;
    int   budget;
    budget = 0;
    while (!(drv_done && sb_q.size() == 0) && budget < 5000) begin
      @(negedge clk);
      #2;
      budget++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("mod10_output_carry", int'(car[0]), int'(e.car0));
        chk("mod16_output_carry", int'(car[1]), int'(e.car1));
        chk("cascade_low_carry", int'(lo_car), int'(e.lo_car));
        chk("cascade_high_carry", int'(hi_car), int'(e.hi_car));
        if (e.kind) begin
          chk_state(e);
        end else begin
          @(posedge clk);
          #1;
          chk_state(e);
        end
      end
    end
    if (budget >= 5000) begin
      errors++;
      checks++;
      $display("FAIL monitor_timeout: got %0d cycles, expected fewer than 5000", budget);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
